// File: rtl/uart_tx_fifo_drain_pkg.sv
// Shared definitions for the UART TX FIFO drain: state encoding, line levels,
// default sizing and a small width helper.
package uart_tx_fifo_drain_pkg;

    // Default sizing: 100 MHz clock at 115200 baud, byte-wide FIFO.
    localparam int DEFAULT_CLKS_PER_BIT = 868;
    localparam int DEFAULT_WIDTH        = 8;

    // UART line levels: idle/stop is mark (1), start is space (0).
    localparam logic LINE_MARK  = 1'b1;
    localparam logic LINE_SPACE = 1'b0;

    // Frame state encoding, in the order a frame walks through them.
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FETCH = 3'd1;
    localparam logic [2:0] ST_WAIT  = 3'd2;
    localparam logic [2:0] ST_START = 3'd3;
    localparam logic [2:0] ST_DATA  = 3'd4;
    localparam logic [2:0] ST_STOP  = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE  = ST_IDLE,
        S_FETCH = ST_FETCH,
        S_WAIT  = ST_WAIT,
        S_START = ST_START,
        S_DATA  = ST_DATA,
        S_STOP  = ST_STOP
    } state_e;

    // Counter width for a range of n values; never below one bit so that
    // degenerate sizes still produce a legal vector.
    function automatic int clog2_min1(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

    // True for the states in which a frame is driving the line.
    function automatic logic is_on_line(input state_e s);
        return (s == S_START) || (s == S_DATA) || (s == S_STOP);
    endfunction

endpackage

// File: rtl/uart_tx_fifo_drain_if.sv
// Read-side handshake between the TX FIFO and the drain block. The drain is
// the master (it issues pops); the FIFO is the slave (it returns words).
interface uart_tx_fifo_drain_if
    import uart_tx_fifo_drain_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);

    logic             fifo_read_enable;  // one-cycle pop request
    logic [WIDTH-1:0] fifo_read_data;    // popped word, meaningful with fifo_valid
    logic             fifo_valid;        // cycle after a pop, iff FIFO was non-empty

    modport master (
        output fifo_read_enable,
        input  fifo_read_data,
        input  fifo_valid
    );

    modport slave (
        input  fifo_read_enable,
        output fifo_read_data,
        output fifo_valid
    );

endinterface

// File: rtl/uart_tx_fifo_drain_baud_counter.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and wraps. The owner clears it
// on every state entry so each bit period starts from zero. tick marks the
// last cycle of a bit period; pre_tick marks the cycle before it, which lets
// the owner register a pulse that lands exactly on that last cycle.
module uart_tx_fifo_drain_baud_counter
    import uart_tx_fifo_drain_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick,
    output logic pre_tick
);

    localparam int            CW       = clog2_min1(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST     = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] PRE_LAST = CW'(CLKS_PER_BIT - 2);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Next count: restart on clear or at the end of a bit period, else advance.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves
        // it unassigned; an unassigned path would infer a latch.
        count_d = count_q;
        if (clear || (count_q == LAST)) begin
            count_d = '0;
        end else begin
            count_d = count_q + 1'b1;
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignment so every flop
        // samples the pre-edge values of the others, independent of order.
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tick     = (count_q == LAST);
    assign pre_tick = (count_q == PRE_LAST);

endmodule

// File: rtl/uart_tx_fifo_drain.sv
// Drains the TX FIFO onto a UART line. While enabled, it pops one word at a
// time (read pulse, then the FIFO's valid in the following cycle) and sends it
// as 1 start bit, WIDTH data bits LSB first and 1 stop bit, no parity.
// An empty FIFO simply sends the FSM back to IDLE, so with enable held high
// the block polls every three cycles while the line stays at mark.
// All outputs come straight from flops.
module uart_tx_fifo_drain
    import uart_tx_fifo_drain_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,  // must be >= 2
    parameter int WIDTH        = DEFAULT_WIDTH
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        enable,
    uart_tx_fifo_drain_if.master        fifo,
    output logic                        tx,
    output logic                        busy,
    output logic                        frame_done
);

    localparam int            IW       = clog2_min1(WIDTH);
    localparam logic [IW-1:0] LAST_BIT = IW'(WIDTH - 1);

    state_e           state_q,      state_d;
    logic [WIDTH-1:0] shift_q,      shift_d;
    logic [IW-1:0]    bit_idx_q,    bit_idx_d;
    logic             tx_q,         tx_d;
    logic             rd_en_q,      rd_en_d;
    logic             busy_q,       busy_d;
    logic             frame_done_q, frame_done_d;

    logic baud_clear;
    logic baud_tick;
    logic baud_pre_tick;

    uart_tx_fifo_drain_baud_counter #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk      (clk),
        .reset    (reset),
        .clear    (baud_clear),
        .tick     (baud_tick),
        .pre_tick (baud_pre_tick)
    );

    // Next-state, shift register and bit index for the frame sequencer.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_idx_d = bit_idx_q;

        case (state_q)
            S_IDLE: begin
                // enable is only looked at here, so dropping it mid-frame
                // lets the current frame finish.
                if (enable) begin
                    state_d = S_FETCH;
                end
            end

            S_FETCH: begin
                // The pop pulse is issued in this cycle; the answer arrives next.
                state_d = S_WAIT;
            end

            S_WAIT: begin
                // Only here is fifo_valid honoured; strays elsewhere are ignored.
                if (fifo.fifo_valid) begin
                    shift_d = fifo.fifo_read_data;
                    state_d = S_START;
                end else begin
                    state_d = S_IDLE;
                end
            end

            S_START: begin
                if (baud_tick) begin
                    bit_idx_d = '0;
                    state_d   = S_DATA;
                end
            end

            S_DATA: begin
                if (baud_tick) begin
                    shift_d = shift_q >> 1;
                    if (bit_idx_q == LAST_BIT) begin
                        state_d = S_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end
            end

            S_STOP: begin
                if (baud_tick) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Baud counter control: restart on every state entry and hold at zero
    // outside the on-line states.
    always_comb begin
        baud_clear = (state_d != state_q) || !is_on_line(state_q);
    end

    // Output decode from the next state, so the registered outputs line up
    // with the state register cycle for cycle.
    always_comb begin
        tx_d = LINE_MARK;
        case (state_d)
            S_START: tx_d = LINE_SPACE;
            S_DATA:  tx_d = shift_d[0];
            default: tx_d = LINE_MARK;
        endcase

        rd_en_d = (state_d == S_FETCH);
        busy_d  = is_on_line(state_d);

        // pre_tick in STOP means the next cycle is the last one of the frame.
        frame_done_d = (state_q == S_STOP) && baud_pre_tick;
    end

    // State, datapath and output registers; reset aborts any frame in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            shift_q      <= '0;
            bit_idx_q    <= '0;
            tx_q         <= LINE_MARK;
            rd_en_q      <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            bit_idx_q    <= bit_idx_d;
            tx_q         <= tx_d;
            rd_en_q      <= rd_en_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign fifo.fifo_read_enable = rd_en_q;
    assign tx                    = tx_q;
    assign busy                  = busy_q;
    assign frame_done            = frame_done_q;

endmodule
